// File: rtl/vc_queue_mux_if.sv
// rtl/vc_queue_mux_if.sv - push/grant/output handshake bundle for vc_queue_mux
interface vc_queue_mux_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          push;
    logic [4*DATA_W-1:0] data_in;
    logic [3:0]          grant;
    logic                ready_in;
    logic [3:0]          full;
    logic [3:0]          empty;
    logic [DATA_W-1:0]   data_out;
    logic [1:0]          vc_out;
    logic                valid_out;
    logic                grant_err;
    logic [7:0]          drop_cnt;

    modport master (
        output push, data_in, grant, ready_in,
        input  full, empty, data_out, vc_out, valid_out, grant_err, drop_cnt
    );

    modport slave (
        input  push, data_in, grant, ready_in,
        output full, empty, data_out, vc_out, valid_out, grant_err, drop_cnt
    );
endinterface

// File: rtl/vc_queue_mux.sv
// rtl/vc_queue_mux.sv - four per-VC FIFOs popped by one-hot grant into a registered output stage; optional drop counter under VC_MUX_STATS_EN
module vc_queue_mux #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    vc_queue_mux_if.slave      bus
);
    localparam int CW = ADDR_W + 1;

    logic [DATA_W-1:0] mem [4][DEPTH];
    logic [ADDR_W-1:0] wr_ptr [4];
    logic [ADDR_W-1:0] rd_ptr [4];
    logic [CW-1:0]     cnt [4];

    logic [3:0]        full_w;
    logic [3:0]        empty_w;
    logic [3:0]        push_ok;
    logic [3:0]        pop;
    logic              load;
    logic              grant_multi;
    logic              grant_onehot;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        head_vc;

    logic [DATA_W-1:0] data_q;
    logic [1:0]        vc_q;
    logic              valid_q;
    logic              grant_err_q;

    // Status comes straight from the registered counts, so it reflects the previous edge
    always_comb begin
        full_w  = '0;
        empty_w = '0;
        for (int i = 0; i < 4; i++) begin
            full_w[i]  = (cnt[i] == CW'(DEPTH));
            empty_w[i] = (cnt[i] == '0);
        end
    end

    // Accept/pop decisions; a full FIFO drops its push even if it pops this cycle
    always_comb begin
        load         = !valid_q || bus.ready_in;
        grant_multi  = (bus.grant & (bus.grant - 4'd1)) != 4'd0;
        grant_onehot = (bus.grant != 4'd0) && !grant_multi;
        push_ok      = bus.push & ~full_w;
        pop          = '0;
        for (int i = 0; i < 4; i++) begin
            pop[i] = load && grant_onehot && bus.grant[i] && !empty_w[i];
        end
    end

    // Head-of-line select for the granted VC
    always_comb begin
        head_data = '0;
        head_vc   = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.grant[i]) begin
                head_data = mem[i][rd_ptr[i]];
                head_vc   = 2'(i);
            end
        end
    end

    // Pointer and occupancy tracking per VC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + ADDR_W'(1);
                if (pop[i])     rd_ptr[i] <= rd_ptr[i] + ADDR_W'(1);
                case ({push_ok[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + CW'(1);
                    2'b01:   cnt[i] <= cnt[i] - CW'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Payload storage; contents survive reset, only pointers are cleared
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push_ok[i]) mem[i][wr_ptr[i]] <= bus.data_in[i*DATA_W +: DATA_W];
        end
    end

    // Output stage: load on pop, clear valid after a transfer with no refill, hold under back-pressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q      <= '0;
            vc_q        <= '0;
            valid_q     <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            grant_err_q <= load && grant_multi;
            if (|pop) begin
                data_q  <= head_data;
                vc_q    <= head_vc;
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready_in) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef VC_MUX_STATS_EN
    logic [7:0] drop_q;
    logic [2:0] n_drop;
    logic [8:0] drop_sum;

    // Number of pushes rejected this cycle and the unsaturated running total
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < 4; i++) begin
            n_drop = n_drop + {2'b00, bus.push[i] & full_w[i]};
        end
        drop_sum = {1'b0, drop_q} + {6'b000000, n_drop};
    end

    // Saturating drop counter, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_q <= '0;
        else       drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = 8'h00;
`endif

    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.data_out  = data_q;
    assign bus.vc_out    = vc_q;
    assign bus.valid_out = valid_q;
    assign bus.grant_err = grant_err_q;
endmodule

// File: doc/vc_queue_mux.md
# vc_queue_mux

Downstream consumer of the QoS round-robin arbiter. Holds one FIFO per virtual channel (VC0–VC3) and, each cycle, pops the FIFO named by the arbiter's one-hot grant into a registered valid/ready output stage feeding the PCIe transmit path. It also reports per-VC full/empty status back to the arbitration logic and flags protocol errors: bad grants and overflow drops.

## Interface
Parameters:
- DATA_W, 8, payload width per entry
- DEPTH, 4, entries per VC FIFO (power of 2, ≥2)
- ADDR_W, 2, log2(DEPTH)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- push  input  4  per-VC write strobe, bit i = VCi
- data_in  input  4*DATA_W  VCi payload in bits [i*DATA_W +: DATA_W]
- grant  input  4  one-hot VC select from the arbiter (bit i = VCi)
- ready_in  input  1  downstream accepts data_out this cycle
- full  output  4  VCi FIFO holds DEPTH entries
- empty  output  4  VCi FIFO holds 0 entries
- data_out  output  DATA_W  registered payload
- vc_out  output  2  VC index of data_out
- valid_out  output  1  data_out/vc_out valid
- grant_err  output  1  one-cycle pulse: grant had more than one bit set
- drop_cnt  output  8  saturating count of rejected pushes (see Configuration)

## Operation
- Four independent circular FIFOs, each with ADDR_W-bit read/write pointers and an (ADDR_W+1)-bit occupancy count. Pointers wrap from DEPTH-1 to 0.
- Push: a write to VCi is accepted iff push[i]=1 and full[i]=0, where full[i] is the registered status at the clock edge. A push to a full FIFO is dropped, even if the same FIFO pops in that cycle.
- Load enable: `load = !valid_out || ready_in`.
- Pop: VCi pops iff load=1, grant is exactly one-hot with bit i set, and empty[i]=0. The head entry is written into data_out, vc_out is set to i, and valid_out is set to 1.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect and the count is unchanged. Push and pop on an empty FIFO: no pop, the push is accepted, and the FIFO is non-empty next cycle.
- grant=0: no pop.
- Multi-hot grant: no pop, and grant_err pulses high for the following cycle.
- Granted FIFO empty: no pop and no error.
- Output register behaviour:
  - Transfer occurs when valid_out && ready_in.
  - If a transfer occurs and no new pop happens, valid_out clears to 0.
  - If valid_out=1 and ready_in=0, data_out and vc_out hold stable.
- FIFO storage contents are not reset; only pointers, counts and outputs are reset.

## Timing
- Reset values: full=0, empty=4'b1111, data_out=0, vc_out=0, valid_out=0, grant_err=0, drop_cnt=0. Reset clears all pointers and counts immediately and asynchronously.
- A reset asserted mid-operation discards every queued entry and any pending output.
- full and empty are registered and reflect pushes/pops from the previous edge.
- Latency:
  - push to earliest possible pop: 1 cycle (the entry is visible in empty at the next edge).
  - grant sample to valid_out: 1 cycle.
- Throughput: one entry per cycle when ready_in=1 and the granted FIFO stays non-empty.
- grant is only sampled when load=1; grants during back-pressure are ignored and are not queued.

## Configuration
- VC_MUX_STATS_EN defined:
  - drop_cnt increments by the number of rejected pushes in the cycle (0–4).
  - drop_cnt saturates at 8'hFF and is cleared only by reset.
- VC_MUX_STATS_EN undefined: drop_cnt is tied to 8'h00 and no counter logic is built.
- Push-drop behaviour is identical in both builds.

## Test plan
- Reset, then push VC2 with 0xA1, 0xA2 and hold grant=4'b0100, ready_in=1:
  - valid_out=1 with data_out=0xA1, vc_out=2 on the cycle after the first pop opportunity.
  - 0xA2 follows on the next cycle.
  - empty[2]=1 afterwards.
- Fill VC0 with 4 entries, then push a 5th (0x55):
  - full[0]=1 and the 5th push is dropped.
  - Draining yields exactly the 4 original values in order.
  - drop_cnt=1 with VC_MUX_STATS_EN, 0 without.
- VC1 holds 0x10, 0x11, grant=4'b0010, ready_in=0 for 3 cycles:
  - data_out stays 0x10 and valid_out stays 1.
  - VC1 count drops by only 1.
  - Releasing ready_in delivers 0x11 on the next cycle.
- With all FIFOs non-empty, drive grant=4'b0101:
  - No pop and valid_out=0.
  - grant_err=1 for exactly one cycle.
  - Occupancy is unchanged.
- Drive grant=4'b1000 with VC3 empty: no pop, valid_out=0, grant_err=0.
- Assert reset asynchronously (mid-cycle) with VC0 holding 3 entries and valid_out=1:
  - valid_out=0 and empty=4'b1111 immediately.
  - The first post-reset push to VC0 reads back correctly.
